// File: rtl/gmii_rx_deframer_pkg.sv
// Shared constants for the GMII receive path: packet codes, framing bytes, CRC.
package gmii_rx_deframer_pkg;

  localparam logic [1:0] PC_DATA   = 2'b00;
  localparam logic [1:0] PC_SOP    = 2'b01;
  localparam logic [1:0] PC_EOP    = 2'b10;
  localparam logic [1:0] PC_BADEOP = 2'b11;

  localparam logic [7:0] GMII_PRE = 8'h55;
  localparam logic [7:0] GMII_SFD = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP,
    ST_FLUSH
  } rx_state_t;

endpackage

// File: rtl/sd_fifo_c.sv
// srdy/drdy FIFO; head entry reads as zero while empty.
module sd_fifo_c #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [WIDTH-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [WIDTH-1:0] p_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = c_srdy && !w_full;
  assign w_rd    = p_drdy && !w_empty;
  assign c_drdy  = !w_full;
  assign p_srdy  = !w_empty;
  assign p_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage array, written on accepted input.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= c_data;
  end

  // Read/write pointers with wrap bit for full/empty distinction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks FCS and length,
// emits tagged bytes through a FIFO and counts good/bad frames.
module gmii_rx_deframer
  import gmii_rx_deframer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MIN_LEN    = 64,
  parameter int unsigned MAX_LEN    = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic        rxg_srdy,
  input  logic        rxg_drdy,
  output logic [1:0]  rxg_code,
  output logic [7:0]  rxg_data,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  rx_state_t        r_state, w_state_nxt;
  logic [7:0]       r_rxd;
  logic             r_dv, r_er;
  logic [31:0]      r_crc, w_crc_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [7:0]       r_stg, w_stg_nxt;
  logic             r_stg_vld, w_stg_vld_nxt;
  logic             r_sop_done, w_sop_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_flush_pend, w_flush_pend_nxt;
  logic [15:0]      r_good, r_bad;
  logic             w_wr, w_good_inc, w_bad_inc;
  logic [1:0]       w_wr_code;
  logic [7:0]       w_wr_data;
  logic             w_fifo_rdy, w_full;
  logic [9:0]       w_wr_word, w_rd_word;

  assign w_full    = !w_fifo_rdy;
  assign w_wr_word = {w_wr_code, w_wr_data};
  assign rxg_code  = w_rd_word[9:8];
  assign rxg_data  = w_rd_word[7:0];
  assign good_cnt  = r_good;
  assign bad_cnt   = r_bad;

  // Input sampling stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd <= '0;
      r_dv  <= 1'b0;
      r_er  <= 1'b0;
    end else begin
      r_rxd <= gmii_rxd;
      r_dv  <= gmii_rx_dv;
      r_er  <= gmii_rx_er;
    end
  end

  // FSM and per-frame state registers, plus saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_crc        <= '0;
      r_len        <= '0;
      r_stg        <= '0;
      r_stg_vld    <= 1'b0;
      r_sop_done   <= 1'b0;
      r_err        <= 1'b0;
      r_flush_pend <= 1'b0;
      r_good       <= '0;
      r_bad        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_crc        <= w_crc_nxt;
      r_len        <= w_len_nxt;
      r_stg        <= w_stg_nxt;
      r_stg_vld    <= w_stg_vld_nxt;
      r_sop_done   <= w_sop_done_nxt;
      r_err        <= w_err_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      if (w_good_inc && r_good != '1) r_good <= r_good + 16'd1;
      if (w_bad_inc  && r_bad  != '1) r_bad  <= r_bad + 16'd1;
    end
  end

  // Next-state, FIFO write and counter-increment decisions.
  // A mid-frame overflow after SOP reuses DROP with r_flush_pend set, so the
  // frame is closed by FLUSH once rx_dv falls.
  always_comb begin
    w_state_nxt      = r_state;
    w_crc_nxt        = r_crc;
    w_len_nxt        = r_len;
    w_stg_nxt        = r_stg;
    w_stg_vld_nxt    = r_stg_vld;
    w_sop_done_nxt   = r_sop_done;
    w_err_nxt        = r_err;
    w_flush_pend_nxt = r_flush_pend;
    w_wr             = 1'b0;
    w_wr_code        = PC_DATA;
    w_wr_data        = '0;
    w_good_inc       = 1'b0;
    w_bad_inc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_dv) begin
          if (r_rxd == GMII_PRE) begin
            w_state_nxt = ST_PRE;
          end else begin
            w_state_nxt      = ST_DROP;
            w_flush_pend_nxt = 1'b0;
            w_bad_inc        = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (!r_dv) begin
          w_state_nxt = ST_IDLE;
          w_bad_inc   = 1'b1;
        end else if (r_er || (r_rxd != GMII_PRE && r_rxd != GMII_SFD)) begin
          w_state_nxt      = ST_DROP;
          w_flush_pend_nxt = 1'b0;
          w_bad_inc        = 1'b1;
        end else if (r_rxd == GMII_SFD) begin
          w_state_nxt      = ST_DATA;
          w_crc_nxt        = CRC_INIT;
          w_len_nxt        = '0;
          w_stg_vld_nxt    = 1'b0;
          w_sop_done_nxt   = 1'b0;
          w_err_nxt        = 1'b0;
          w_flush_pend_nxt = 1'b0;
        end
      end
      ST_DATA: begin
        if (r_dv) begin
          if (r_stg_vld && w_full) begin
            w_state_nxt      = ST_DROP;
            w_flush_pend_nxt = r_sop_done;
            w_bad_inc        = !r_sop_done;
          end else begin
            w_crc_nxt     = crc_next(r_crc, r_rxd);
            w_len_nxt     = (r_len == LEN_SAT) ? r_len : r_len + LEN_W'(1);
            w_stg_nxt     = r_rxd;
            w_stg_vld_nxt = 1'b1;
            w_err_nxt     = r_err | r_er;
            if (r_stg_vld) begin
              w_wr           = 1'b1;
              w_wr_code      = r_sop_done ? PC_DATA : PC_SOP;
              w_wr_data      = r_stg;
              w_sop_done_nxt = 1'b1;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
          if (!r_sop_done) begin
            w_bad_inc = 1'b1;
          end else if (w_full) begin
            w_state_nxt = ST_FLUSH;
          end else begin
            w_wr      = 1'b1;
            w_wr_data = r_stg;
            if (r_crc == CRC_RESIDUE && r_len >= LEN_W'(MIN_LEN) &&
                r_len <= LEN_W'(MAX_LEN) && !r_err) begin
              w_wr_code  = PC_EOP;
              w_good_inc = 1'b1;
            end else begin
              w_wr_code = PC_BADEOP;
              w_bad_inc = 1'b1;
            end
          end
        end
      end
      ST_DROP: begin
        if (!r_dv) begin
          w_state_nxt      = r_flush_pend ? ST_FLUSH : ST_IDLE;
          w_flush_pend_nxt = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (!w_full) begin
          w_wr        = 1'b1;
          w_wr_code   = PC_BADEOP;
          w_wr_data   = '0;
          w_bad_inc   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  sd_fifo_c #(
    .WIDTH(10),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (w_wr),
    .c_drdy (w_fifo_rdy),
    .c_data (w_wr_word),
    .p_srdy (rxg_srdy),
    .p_drdy (rxg_drdy),
    .p_data (w_rd_word)
  );

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Bench for gmii_rx_deframer: frame table plus stall, back-to-back and reset sequences.
module tb_gmii_rx_deframer;

  logic        clk;
  logic        reset;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic        rxg_srdy;
  logic        rxg_drdy;
  logic [1:0]  rxg_code;
  logic [7:0]  rxg_data;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_deframer #(
    .FIFO_DEPTH(16),
    .MIN_LEN(64),
    .MAX_LEN(1518)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .rxg_srdy   (rxg_srdy),
    .rxg_drdy   (rxg_drdy),
    .rxg_code   (rxg_code),
    .rxg_data   (rxg_data),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  localparam logic [1:0] C_DATA = 2'b00, C_SOP = 2'b01, C_EOP = 2'b10, C_BAD = 2'b11;

  typedef struct {
    int unsigned len;
    int unsigned seed;
    bit          corrupt;
    int          er_at;
    bit          bad_pre;
    bit          exp_good;
  } vec_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  frm[$];
  int unsigned drdy_mode = 0;   // 0 always ready, 1 stalled, 2 random
  bit          sb_ignore = 0;
  int unsigned exp_good = 0;
  int unsigned exp_bad  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every transferred entry with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && !sb_ignore && rxg_srdy && rxg_drdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_entry", {22'd0, rxg_code, rxg_data}, 32'hFFFFFFFF);
      end else begin
        chk("entry", {22'd0, rxg_code, rxg_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // Downstream ready generator; random mode limits stalls per frame so the FIFO never fills.
  initial begin
    int unsigned lows;
    lows = 0;
    rxg_drdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (drdy_mode)
        0: rxg_drdy = 1'b1;
        1: rxg_drdy = 1'b0;
        default: begin
          if (!gmii_rx_dv) begin
            lows = 0;
            rxg_drdy = 1'b1;
          end else if (lows < 8 && $urandom_range(0, 3) == 0) begin
            lows++;
            rxg_drdy = 1'b0;
          end else begin
            rxg_drdy = 1'b1;
          end
        end
      endcase
    end
  end

  // Reference FCS in reflected (right-shift) form.
  task automatic build_frame(input int unsigned len, input int unsigned seed);
    logic [31:0] crc;
    logic [7:0]  b;
    frm.delete();
    for (int unsigned i = 1; i <= 6; i++) frm.push_back(8'(i));
    for (int unsigned i = 10; i <= 15; i++) frm.push_back(8'(i));
    while (frm.size() < len - 4) frm.push_back(8'(frm.size() * 7 + seed));
    crc = 32'hFFFFFFFF;
    for (int unsigned i = 0; i < frm.size(); i++) begin
      b = frm[i];
      crc = crc ^ {24'd0, b};
      for (int unsigned k = 0; k < 8; k++)
        crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    frm.push_back(crc[7:0]);
    frm.push_back(crc[15:8]);
    frm.push_back(crc[23:16]);
    frm.push_back(crc[31:24]);
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(posedge clk);
    #1;
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
  endtask

  task automatic gap(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic push_frame(input logic [1:0] last);
    for (int unsigned i = 0; i < frm.size(); i++)
      exp_q.push_back({(i == 0) ? C_SOP : (i == frm.size() - 1) ? last : C_DATA, frm[i]});
  endtask

  task automatic send_frame(input int er_at);
    for (int unsigned i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < frm.size(); i++) drive(frm[i], 1'b1, (i == er_at));
    gap(12);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    gap(4);
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_good_cnt"}, {16'd0, good_cnt}, exp_good);
    chk({name, "_bad_cnt"}, {16'd0, bad_cnt}, exp_bad);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{len: 64,   seed: 3,  corrupt: 0, er_at: -1, bad_pre: 0, exp_good: 1};
    vecs[1] = '{len: 64,   seed: 3,  corrupt: 1, er_at: -1, bad_pre: 0, exp_good: 0};
    vecs[2] = '{len: 60,   seed: 5,  corrupt: 0, er_at: -1, bad_pre: 0, exp_good: 0};
    vecs[3] = '{len: 1519, seed: 9,  corrupt: 0, er_at: -1, bad_pre: 0, exp_good: 0};
    vecs[4] = '{len: 64,   seed: 1,  corrupt: 0, er_at: -1, bad_pre: 1, exp_good: 0};
    vecs[5] = '{len: 65,   seed: 11, corrupt: 0, er_at: -1, bad_pre: 0, exp_good: 1};
    vecs[6] = '{len: 64,   seed: 2,  corrupt: 0, er_at: 30, bad_pre: 0, exp_good: 0};

    gmii_rxd = 8'h00;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_srdy", {31'd0, rxg_srdy}, 0);
    chk("rst_code", {30'd0, rxg_code}, 0);
    chk("rst_data", {24'd0, rxg_data}, 0);
    chk_counts("rst");
    reset = 1'b0;
    gap(4);

    // Table-driven single frames.
    for (int unsigned v = 0; v < 7; v++) begin
      build_frame(vecs[v].len, vecs[v].seed);
      if (vecs[v].corrupt) frm[20] = frm[20] ^ 8'h04;
      if (vecs[v].bad_pre) begin
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h12, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 20; i++) drive(frm[i], 1'b1, 1'b0);
        gap(12);
        exp_bad++;
      end else begin
        push_frame(vecs[v].exp_good ? C_EOP : C_BAD);
        send_frame(vecs[v].er_at);
        if (vecs[v].exp_good) exp_good++;
        else exp_bad++;
      end
      wait_drain($sformatf("vec%0d", v));
      chk_counts($sformatf("vec%0d", v));
    end

    // Stalled consumer: FIFO fills after SOP + 15 DATA, frame closes with BADEOP 0.
    build_frame(64, 4);
    for (int unsigned i = 0; i < 16; i++) exp_q.push_back({(i == 0) ? C_SOP : C_DATA, frm[i]});
    exp_q.push_back({C_BAD, 8'h00});
    drdy_mode = 1;
    gap(1);
    send_frame(-1);
    chk("ovf_held_srdy", {31'd0, rxg_srdy}, 1);
    chk("ovf_held_queue", exp_q.size(), 17);
    drdy_mode = 0;
    exp_bad++;
    wait_drain("ovf");
    chk_counts("ovf");
    build_frame(64, 6);
    push_frame(C_EOP);
    send_frame(-1);
    exp_good++;
    wait_drain("post_ovf");
    chk_counts("post_ovf");

    // Back-to-back frames with random downstream stalls.
    drdy_mode = 2;
    for (int unsigned f = 0; f < 3; f++) begin
      build_frame(64, 20 + f);
      push_frame(C_EOP);
      send_frame(-1);
      exp_good++;
    end
    wait_drain("b2b");
    drdy_mode = 0;
    gap(2);
    chk_counts("b2b");

    // Reset in the middle of a frame.
    sb_ignore = 1;
    build_frame(64, 30);
    for (int unsigned i = 0; i < 8; i++) drive((i == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 30; i++) drive(frm[i], 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    gmii_rx_dv = 1'b0;
    #1;
    chk("midrst_srdy", {31'd0, rxg_srdy}, 0);
    chk("midrst_code", {30'd0, rxg_code}, 0);
    chk("midrst_data", {24'd0, rxg_data}, 0);
    exp_good = 0;
    exp_bad = 0;
    chk_counts("midrst");
    gap(3);
    reset = 1'b0;
    sb_ignore = 0;
    gap(3);
    build_frame(64, 31);
    push_frame(C_EOP);
    send_frame(-1);
    exp_good++;
    wait_drain("after_rst");
    chk_counts("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
